mem_access_ctrl: RTL and testbench

//  Sequences load/store data-memory accesses for the MIPS datapath.
//  - Forms the effective address as base + sign-extended 16-bit immediate.
//  - Drives a req/ack handshake to data memory and stalls the pipeline until the access completes.
//  - Reports misalignment, illegal-op and timeout errors.
//  - Sits between the decode/execute stage and the data memory port.

---
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundles the pipeline-side op signals and the data-memory port of mem_access_ctrl.
// master = the access controller, slave = pipeline plus data memory.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16
);
  logic                  op_valid;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] base;
  logic [IMM_WIDTH-1:0]  immediate;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] rdata_out;
  logic [1:0]            err;

  modport master (
    input  op_valid, mem_read, mem_write, base, immediate, wdata, dmem_ack, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, done, rdata_out, err
  );

  modport slave (
    output op_valid, mem_read, mem_write, base, immediate, wdata, dmem_ack, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, done, rdata_out, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: effective address, req/ack handshake, pipeline stall, error reporting.
// Optional ALIGN_CHECK_EN macro rejects word accesses with ea[1:0] != 0 (err=01).
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int TIMEOUT    = 16,
  parameter int TO_WIDTH   = 5
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam bit                  TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  state_t                r_state;
  logic [TO_WIDTH-1:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_ea;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_we;
  logic                  r_req;
  logic                  r_done;
  logic [1:0]            r_err;

  logic [DATA_WIDTH-1:0] w_ea;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_misalign;

  assign w_ea      = bus.base + {{(DATA_WIDTH-IMM_WIDTH){bus.immediate[IMM_WIDTH-1]}}, bus.immediate};
  assign w_accept  = (r_state == S_IDLE) & bus.op_valid & (bus.mem_read | bus.mem_write);
  assign w_illegal = bus.mem_read & bus.mem_write;

`ifdef ALIGN_CHECK_EN
  assign w_misalign = |w_ea[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ea    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ea    <= w_ea;
            r_we    <= bus.mem_write;
            r_wdata <= bus.wdata;
            r_cnt   <= '0;
            if (w_illegal) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= ERR_ILLEGAL;
            end else if (w_misalign) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= ERR_MISALIGN;
            end else begin
              r_state <= S_ACCESS;
              r_req   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus.dmem_ack) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= ERR_OK;
            if (!r_we) r_rdata <= bus.dmem_rdata;
          end else if (TO_EN && (r_cnt == TO_LAST)) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= ERR_TIMEOUT;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= ERR_OK;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The accept term makes stall combinational so the op is held in the accept cycle.
  assign bus.stall      = (r_state == S_ACCESS) | w_accept;
  assign bus.dmem_req   = r_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_ea;
  assign bus.dmem_wdata = r_wdata;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.rdata_out  = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level model fills per-cycle
// expectations, one negedge process compares; directed cases pin the model with literals.
module tb_mem_access_ctrl;

  localparam int DW      = 32;
  localparam int IW      = 16;
  localparam int TIMEOUT = 16;
  localparam int MAXC    = 8192;

  logic clk;
  logic rst_n;
  int   cyc;

  mem_access_ctrl_if #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) bus ();

  mem_access_ctrl #(
    .DATA_WIDTH(DW),
    .IMM_WIDTH (IW),
    .TIMEOUT   (TIMEOUT),
    .TO_WIDTH  (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle expectations, filled from whole transactions.
  logic        exp_req  [MAXC];
  logic        exp_we   [MAXC];
  logic        exp_stall[MAXC];
  logic        exp_done [MAXC];
  logic [1:0]  exp_err  [MAXC];
  logic [31:0] exp_addr [MAXC];
  logic [31:0] exp_wdata[MAXC];
  logic [31:0] exp_rdata[MAXC];
  logic [31:0] m_rdata;
  bit          chk_en;

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_req[i]   = 1'b0;
      exp_we[i]    = 1'b0;
      exp_stall[i] = 1'b0;
      exp_done[i]  = 1'b0;
      exp_err[i]   = 2'b00;
      exp_addr[i]  = '0;
      exp_wdata[i] = '0;
      exp_rdata[i] = m_rdata;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n && cyc < MAXC) begin
      check("dmem_req", 32'(bus.dmem_req), 32'(exp_req[cyc]));
      check("stall",    32'(bus.stall),    32'(exp_stall[cyc]));
      check("done",     32'(bus.done),     32'(exp_done[cyc]));
      check("err",      32'(bus.err),      32'(exp_err[cyc]));
      check("rdata_out", bus.rdata_out,    exp_rdata[cyc]);
      if (exp_req[cyc]) begin
        check("dmem_we",    32'(bus.dmem_we), 32'(exp_we[cyc]));
        check("dmem_addr",  bus.dmem_addr,    exp_addr[cyc]);
        if (exp_we[cyc]) check("dmem_wdata", bus.dmem_wdata, exp_wdata[cyc]);
      end
    end
  end

  // Observation for the literal pins: request-cycle count and last reported err.
  int         req_cnt;
  logic [1:0] last_err;
  always @(negedge clk) begin
    if (bus.dmem_req) req_cnt++;
    if (bus.done) last_err = bus.err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.op_valid   = 1'($urandom);
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.base       = $urandom;
      bus.dmem_ack   = 1'($urandom);
      bus.dmem_rdata = $urandom;
      tick();
    end
  endtask

  // Presents one op in the current (idle) cycle; d = cycles from first request to ack.
  // Returns at the first idle cycle after the completion pulse.
  task automatic run_op(input bit rd, input bit wr, input logic [31:0] base,
                        input logic [15:0] imm, input logic [31:0] wd, input int d,
                        input logic [31:0] rv, output logic [31:0] ea_o, output int lat_o);
    logic [31:0] ea;
    logic [1:0]  e;
    int          c0, k, cd;
    bit          mis;
    ea  = base + 32'(int'($signed(imm)));
    mis = 1'b0;
`ifdef ALIGN_CHECK_EN
    mis = (ea[1:0] != 2'b00);
`endif
    if (rd && wr)                        begin e = 2'b11; k = 0; end
    else if (mis)                        begin e = 2'b01; k = 0; end
    else if (TIMEOUT == 0 || d < TIMEOUT) begin e = 2'b00; k = d + 1; end
    else                                 begin e = 2'b10; k = TIMEOUT; end
    c0 = cyc;
    cd = c0 + k + 1;
    if (cd + 1 >= MAXC) begin
      $display("FAIL cycle_budget: cycle %0d beyond %0d", cd, MAXC);
      $fatal(1);
    end
    exp_stall[c0] = 1'b1;
    for (int j = 1; j <= k; j++) begin
      exp_req[c0+j]   = 1'b1;
      exp_stall[c0+j] = 1'b1;
      exp_we[c0+j]    = wr;
      exp_addr[c0+j]  = ea;
      exp_wdata[c0+j] = wd;
    end
    exp_done[cd] = 1'b1;
    exp_err[cd]  = e;
    if (e == 2'b00 && !wr) m_rdata = rv;
    else if (e == 2'b10)   m_rdata = '0;
    for (int i = cd; i < MAXC; i++) exp_rdata[i] = m_rdata;

    req_cnt        = 0;
    bus.op_valid   = 1'b1;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.base       = base;
    bus.immediate  = imm;
    bus.wdata      = wd;
    bus.dmem_ack   = 1'($urandom);
    bus.dmem_rdata = $urandom;
    for (int j = 1; j <= k; j++) begin
      tick();
      bus.op_valid   = 1'($urandom);
      bus.mem_read   = 1'($urandom);
      bus.mem_write  = 1'($urandom);
      bus.base       = $urandom;
      bus.immediate  = 16'($urandom);
      bus.wdata      = $urandom;
      bus.dmem_ack   = (e == 2'b00) && (j == d + 1);
      bus.dmem_rdata = bus.dmem_ack ? rv : $urandom;
    end
    tick();
    // Completion cycle: a re-presented op here must be ignored.
    bus.op_valid   = 1'b1;
    bus.mem_read   = 1'($urandom);
    bus.mem_write  = 1'b1;
    bus.dmem_ack   = 1'($urandom);
    bus.dmem_rdata = $urandom;
    tick();
    bus.op_valid = 1'b0;
    bus.dmem_ack = 1'b0;
    ea_o  = ea;
    lat_o = cd - c0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ea;
    int          lat;
    bit          rd, wr;
    int          d, sel;
    logic [31:0] b;

    rst_n          = 1'b0;
    chk_en         = 1'b0;
    m_rdata        = '0;
    bus.op_valid   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.base       = '0;
    bus.immediate  = '0;
    bus.wdata      = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    req_cnt        = 0;
    last_err       = 2'b00;
    clear_from(0);
    repeat (3) tick();

    check("rst_dmem_req",  32'(bus.dmem_req), 32'd0);
    check("rst_stall",     32'(bus.stall),    32'd0);
    check("rst_done",      32'(bus.done),     32'd0);
    check("rst_err",       32'(bus.err),      32'd0);
    check("rst_rdata_out", bus.rdata_out,     32'd0);
    check("rst_dmem_addr", bus.dmem_addr,     32'd0);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // Load, one-cycle ack.
    run_op(1'b1, 1'b0, 32'h1000, 16'hFFFC, 32'h0, 0, 32'hCAFEF00D, ea, lat);
    check("load_ea",      ea,  32'h00000FFC);
    check("load_latency", 32'(lat), 32'd2);
    check("load_reqs",    32'(req_cnt), 32'd1);
    check("load_rdata",   bus.rdata_out, 32'hCAFEF00D);

    // Store, ack three cycles after the first request.
    run_op(1'b0, 1'b1, 32'h20, 16'h0010, 32'h5A5A5A5A, 3, 32'h0, ea, lat);
    check("store_ea",      ea,  32'h00000030);
    check("store_latency", 32'(lat), 32'd5);
    check("store_reqs",    32'(req_cnt), 32'd4);
    check("store_keeps_rdata", bus.rdata_out, 32'hCAFEF00D);

    // Timeout: never acked.
    run_op(1'b1, 1'b0, 32'h200, 16'h0004, 32'h0, 1000, 32'h0, ea, lat);
    check("timeout_reqs",  32'(req_cnt), 32'd16);
    check("timeout_latency", 32'(lat), 32'd17);
    check("timeout_err",   32'(last_err), 32'd2);
    check("timeout_rdata", bus.rdata_out, 32'd0);

    // Ack in the last allowed cycle beats the timeout.
    run_op(1'b1, 1'b0, 32'h300, 16'h0000, 32'h0, 15, 32'h12345678, ea, lat);
    check("lastack_reqs", 32'(req_cnt), 32'd16);
    check("lastack_err",  32'(last_err), 32'd0);

    // Address wrap.
    run_op(1'b1, 1'b0, 32'hFFFFFFF8, 16'h0010, 32'h0, 1, 32'h0BADBEEF, ea, lat);
    check("wrap_ea", ea, 32'h00000008);

    // Illegal op.
    run_op(1'b1, 1'b1, 32'h40, 16'h0000, 32'h0, 0, 32'h0, ea, lat);
    check("illegal_latency", 32'(lat), 32'd1);
    check("illegal_reqs",    32'(req_cnt), 32'd0);
    check("illegal_err",     32'(last_err), 32'd3);

    // Misaligned effective address.
    run_op(1'b1, 1'b0, 32'h100, 16'h0002, 32'h0, 0, 32'h77777777, ea, lat);
    check("misalign_ea", ea, 32'h00000102);
`ifdef ALIGN_CHECK_EN
    check("misalign_reqs", 32'(req_cnt), 32'd0);
    check("misalign_err",  32'(last_err), 32'd1);
`else
    check("misalign_reqs", 32'(req_cnt), 32'd1);
    check("misalign_err",  32'(last_err), 32'd0);
`endif

    // Reset in the middle of an access.
    chk_en         = 1'b0;
    bus.op_valid   = 1'b1;
    bus.mem_read   = 1'b1;
    bus.mem_write  = 1'b0;
    bus.base       = 32'h80;
    bus.immediate  = 16'h0;
    tick();
    bus.op_valid   = 1'b0;
    bus.mem_read   = 1'b0;
    repeat (2) tick();
    check("midreset_pre_req", 32'(bus.dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_req",   32'(bus.dmem_req), 32'd0);
    check("midreset_stall", 32'(bus.stall),    32'd0);
    check("midreset_done",  32'(bus.done),     32'd0);
    repeat (2) tick();
    rst_n   = 1'b1;
    m_rdata = '0;
    clear_from(cyc);
    tick();
    chk_en = 1'b1;
    run_op(1'b1, 1'b0, 32'h1000, 16'h0008, 32'h0, 0, 32'hA5A5F00D, ea, lat);
    check("post_reset_latency", 32'(lat), 32'd2);
    check("post_reset_rdata",   bus.rdata_out, 32'hA5A5F00D);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      sel = int'($urandom_range(0, 7));
      rd  = (sel <= 4);
      wr  = (sel == 0) || (sel >= 5);
      b   = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h0000FFFC);
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       d = int'($urandom_range(0, 3));
      else if (sel == 6) d = 15;
      else if (sel == 7) d = 16;
      else if (sel == 8) d = 20;
      else               d = int'($urandom_range(5, 8));
      run_op(rd, wr, b, 16'($urandom), $urandom, d, $urandom, ea, lat);
      idle(int'($urandom_range(0, 2)));
    end

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
